// File: rtl/digit_scan_mux_pkg.sv
// Shared definitions for the digit scanner: index-width helper, the
// dark-anode constant and the board-clock refresh default.
package digit_scan_mux_pkg;

    // Refresh divider for the board clock (clk cycles per lit digit).
    localparam int unsigned DEFAULT_REFRESH_DIV = 100000;

    // Widest anode bus that ANODE_OFF can cover.
    localparam int unsigned MAX_DIGITS = 32;

    // Active-low anodes: all ones turns every digit off.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/digit_scan_mux_refresh_prescaler.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 while en is high, holds while
// en is low, and flags the last count of each digit period.
// Ports:
//   clk, reset (async, active-low), en  - clock, reset, count enable
//   cnt                                 - registered count (only with DIGIT_SCAN_BLANK_EN)
//   tick_c                              - combinational end-of-period flag
// Macro: DIGIT_SCAN_BLANK_EN exposes cnt for anode blanking.
module digit_scan_mux_refresh_prescaler
    import digit_scan_mux_pkg::*;
#(
    parameter  int unsigned REFRESH_DIV = DEFAULT_REFRESH_DIV,
    localparam int unsigned CNT_W       = idx_width(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
`ifdef DIGIT_SCAN_BLANK_EN
    output logic [CNT_W-1:0] cnt,
`endif
    output logic             tick_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count and end-of-period flag.
    always_comb begin
        cnt_d  = cnt_q;
        tick_c = en && (cnt_q == CNT_W'(REFRESH_DIV - 1));
        if (tick_c) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef DIGIT_SCAN_BLANK_EN
    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/digit_scan_mux.sv
// Self-timed seven-segment digit scanner. Holds a tear-free snapshot of
// NUM_DIGITS digit values and cycles through them, one per REFRESH_DIV clks.
// Ports:
//   clk, reset (async, active-low)  - clock and reset
//   en                              - scan enable; low freezes scan and darkens display
//   digits_in, digit_mask           - packed digit values and per-digit lit mask
//   digit_q, seg_sel, anode_n       - registered digit value, index, active-low anodes
//   frame_tick                      - one-cycle pulse when seg_sel wraps to 0
// Macro: DIGIT_SCAN_BLANK_EN darkens the anodes for the first BLANK_CYCLES
// clks of every digit period (anti-ghosting).
module digit_scan_mux
    import digit_scan_mux_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS   = 8,
    parameter  int unsigned DATA_W       = 4,
    parameter  int unsigned REFRESH_DIV  = DEFAULT_REFRESH_DIV,
    parameter  int unsigned BLANK_CYCLES = 16,
    localparam int unsigned SEL_W        = idx_width(NUM_DIGITS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_DIGITS*DATA_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]        digit_mask,
    output logic [DATA_W-1:0]            digit_q,
    output logic [SEL_W-1:0]             seg_sel,
    output logic [NUM_DIGITS-1:0]        anode_n,
    output logic                         frame_tick
);

    localparam int unsigned           CNT_W       = idx_width(REFRESH_DIV);
    localparam logic [NUM_DIGITS-1:0] ANODES_DARK = NUM_DIGITS'(ANODE_OFF);

    // Reject parameter sets the scanner cannot honour.
    if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS || REFRESH_DIV < 2 ||
        BLANK_CYCLES >= REFRESH_DIV) begin : g_param_err
        $error("digit_scan_mux: illegal parameter set");
    end

    logic                         tick_c;
    logic                         wrap_c;
    logic                         load_c;
    logic [DATA_W-1:0]            digit_sel_c;
    logic [NUM_DIGITS-1:0]        onehot_c;

    logic [SEL_W-1:0]             seg_sel_q,   seg_sel_d;
    logic [NUM_DIGITS*DATA_W-1:0] shadow_q,    shadow_d;
    logic [NUM_DIGITS-1:0]        mask_q,      mask_d;
    logic                         load_pend_q, load_pend_d;
    logic [DATA_W-1:0]            cur_digit_q, cur_digit_d;
    logic [NUM_DIGITS-1:0]        anode_q,     anode_d;
    logic                         frame_q,     frame_d;

`ifdef DIGIT_SCAN_BLANK_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt_c;
`endif

    digit_scan_mux_refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
`ifdef DIGIT_SCAN_BLANK_EN
        .cnt    (cnt),
`endif
        .tick_c (tick_c)
    );

`ifdef DIGIT_SCAN_BLANK_EN
    // Count value that will be live after this edge, aligned with the outputs.
    assign cnt_nxt_c = tick_c ? '0 : (en ? cnt + CNT_W'(1) : cnt);
`endif

    // Select advance, snapshot load and next output values.
    always_comb begin
        seg_sel_d   = seg_sel_q;
        wrap_c      = 1'b0;
        digit_sel_c = '0;
        onehot_c    = '0;

        if (tick_c) begin
            if (seg_sel_q == SEL_W'(NUM_DIGITS - 1)) begin
                seg_sel_d = '0;
                wrap_c    = 1'b1;
            end else begin
                seg_sel_d = seg_sel_q + SEL_W'(1);
            end
        end

        // Snapshot on the wrap edge, or on the first enabled cycle after reset.
        load_c      = wrap_c || (en && load_pend_q);
        shadow_d    = load_c ? digits_in  : shadow_q;
        mask_d      = load_c ? digit_mask : mask_q;
        load_pend_d = load_pend_q && !load_c;

        // Outputs look at next-state select and shadow so a wrap never shows stale data.
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (seg_sel_d == SEL_W'(k)) begin
                digit_sel_c = shadow_d[k*DATA_W +: DATA_W];
                onehot_c[k] = 1'b1;
            end
        end

        cur_digit_d = digit_sel_c;
        anode_d     = en ? ~(onehot_c & mask_d) : ANODES_DARK;
`ifdef DIGIT_SCAN_BLANK_EN
        if (cnt_nxt_c < CNT_W'(BLANK_CYCLES)) begin
            anode_d = ANODES_DARK;
        end
`endif
        frame_d     = wrap_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_sel_q   <= '0;
            shadow_q    <= '0;
            mask_q      <= '0;
            load_pend_q <= 1'b1;
            cur_digit_q <= '0;
            anode_q     <= ANODES_DARK;
            frame_q     <= 1'b0;
        end else begin
            seg_sel_q   <= seg_sel_d;
            shadow_q    <= shadow_d;
            mask_q      <= mask_d;
            load_pend_q <= load_pend_d;
            cur_digit_q <= cur_digit_d;
            anode_q     <= anode_d;
            frame_q     <= frame_d;
        end
    end

    assign digit_q    = cur_digit_q;
    assign seg_sel    = seg_sel_q;
    assign anode_n    = anode_q;
    assign frame_tick = frame_q;

endmodule

// File: doc/digit_scan_mux.md
Name: digit_scan_mux

Overview:
Parametrised, self-timed digit scanner for the multiplexed seven-segment display. It replaces the fixed 4-way combinational digit mux and the external select source with one block. The block stores a tear-free snapshot of N digit values and cycles through them at a programmable refresh rate. It drives the selected digit value, the select index, the active-low anodes and a frame pulse. It sits between the display-data sources and the segment decoder.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits; must be at least 2.
- DATA_W, 4, bit width of each digit value.
- REFRESH_DIV, 100000, clk cycles each digit stays lit; must be at least 2.
- BLANK_CYCLES, 16, dark cycles at the start of each digit period (used only with the macro); must be less than REFRESH_DIV.
- Derived localparam SEL_W = $clog2(NUM_DIGITS).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- en, input, 1, scan enable; when low, scanning freezes and the display goes dark.
- digits_in, input, NUM_DIGITS*DATA_W, packed digit values; digit k occupies bits [k*DATA_W +: DATA_W].
- digit_mask, input, NUM_DIGITS, 1 means digit k is lit; 0 means digit k is blanked.
- digit_q, output, DATA_W, registered value of the currently selected digit.
- seg_sel, output, SEL_W, registered index of the current digit.
- anode_n, output, NUM_DIGITS, registered, active-low, one-hot-or-none anode drive.
- frame_tick, output, 1, one-cycle pulse when seg_sel wraps to 0.

Behaviour:
- Reset (asynchronous, while reset=0): prescaler=0, seg_sel=0, digit_q=0, anode_n=all 1, frame_tick=0, shadow data/mask=0, load_pend=1.
- Prescaler: counts 0..REFRESH_DIV-1 while en=1 and holds while en=0. tick = en & (cnt==REFRESH_DIV-1). On tick, cnt returns to 0.
- Select advance on tick:
  - seg_sel increments; at NUM_DIGITS-1 it wraps to 0.
  - The wrap cycle registers frame_tick=1 for exactly one cycle; frame_tick is 0 at all other times.
- Snapshot:
  - Shadow data and mask load from digits_in/digit_mask in the same edge that wraps seg_sel to 0.
  - They also load on the first en=1 cycle while load_pend=1; that load clears load_pend.
  - Input changes mid-frame are never visible until the next frame.
- Outputs:
  - digit_q = shadow[seg_sel_next] and anode_n = ~(onehot(seg_sel_next) & shadow_mask) are registered together with seg_sel.
  - All three change on the same edge.
  - Latency from tick to the new digit on the pins is 1 cycle.
  - On a wrap, the output uses the freshly loaded shadow (next-state values), never the stale frame.
- en=0: anode_n=all 1 from the next edge. seg_sel, digit_q, cnt and shadow hold. Re-asserting en resumes from the held cnt and seg_sel.
- Reset mid-frame returns everything to reset values. The first frame after release starts at digit 0 with a fresh snapshot.
- Non-power-of-2 NUM_DIGITS: seg_sel never exceeds NUM_DIGITS-1.

Optional Feature:
- Macro: DIGIT_SCAN_BLANK_EN.
- Defined: anode_n is forced all-1 while cnt < BLANK_CYCLES in every digit period, to suppress ghosting. seg_sel and digit_q update as normal; only the anodes are gated.
- Undefined: no blanking logic, and BLANK_CYCLES is unused.

Decomposition:
- Shared package/header holds:
  - clog2-based width helper.
  - ANODE_OFF constant (all ones, active-low).
  - Default REFRESH_DIV for the board clock.
- One natural sub-module: refresh_prescaler (counter with en, producing tick and exposing cnt for blanking).
- Select, snapshot and output registers stay in the top module.

Test Plan:
Bench parameters: NUM_DIGITS=4, DATA_W=4, REFRESH_DIV=4.
1. Reset release, en=1, digits_in=16'h4321, mask=4'hF: seg_sel steps 0,1,2,3,0 every 4 clks; digit_q=1,2,3,4; anode_n=1110,1101,1011,0111; frame_tick pulses once per 16 clks.
2. Change digits_in to 16'hABCD while seg_sel=1: digit_q continues 2,3,4; after the wrap, digit_q shows D,C,B,A.
3. digit_mask=4'b0101: anode_n=1110 at seg_sel 0, 1111 at 1, 1011 at 2, 1111 at 3; digit_q still cycles through all values.
4. Drop en for 10 clks at seg_sel=2: anode_n=1111 from the next edge, and seg_sel and digit_q hold. Re-assert en: scanning resumes at digit 2 with the remaining cnt.
5. Assert reset asynchronously mid-cycle at seg_sel=3: outputs reach reset values immediately, without waiting for a clk edge. After release, the first digit is 0 with a fresh snapshot.
6. With DIGIT_SCAN_BLANK_EN and BLANK_CYCLES=1: anode_n=1111 in the first clk of each 4-clk digit period and the normal one-hot pattern in the remaining 3.
